// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's decode-side syscall sequencer:
// syscall codes, console item types, sequencer states and a byte-lane helper.
package mips_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  localparam logic [1:0]  CON_CHAR      = 2'd0;
  localparam logic [1:0]  CON_INT       = 2'd1;
  localparam logic [31:0] CON_NEWLINE   = 32'h0000_000A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INT,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_NL,
    ST_DONE,
    ST_HALT
  } sys_state_t;

  // Little-endian byte lane: lane 0 is bits [7:0].
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/syscall_ctrl_if.sv
// Decode-stage syscall operands, memory read port and console stream of the
// syscall sequencer; master is the sequencer, slave is the core/console side.
interface syscall_ctrl_if;
  import mips_pkg::*;

  logic        sys;
  logic [31:0] regv;
  logic [31:0] rega;
  logic        stall;
  logic        mem_rd;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        con_valid;
  logic        con_ready;
  logic [1:0]  con_type;
  logic [31:0] con_data;
  logic        halt;

  modport master (
    input  sys, regv, rega, mem_data, con_ready,
    output stall, mem_rd, mem_addr, con_valid, con_type, con_data, halt
  );

  modport slave (
    output sys, regv, rega, mem_data, con_ready,
    input  stall, mem_rd, mem_addr, con_valid, con_type, con_data, halt
  );

endinterface

// File: rtl/syscall_ctrl.sv
// Syscall sequencer: stalls decode on a syscall, services print-int,
// print-string (via the memory read port) and exit, then releases or halts.
module syscall_ctrl
  import mips_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  syscall_ctrl_if.master bus
);

  localparam int WW = $clog2(MAX_WORDS + 1);
  typedef logic [WW-1:0] widx_t;
  localparam widx_t LAST_WIDX = widx_t'(MAX_WORDS - 1);

  sys_state_t  state;
  logic [29:0] loc;
  widx_t       widx;
  logic [1:0]  bidx;
  logic [31:0] word;

  logic        mem_rd_q;
  logic [29:0] mem_addr_q;
  logic        con_valid_q;
  logic [1:0]  con_type_q;
  logic [31:0] con_data_q;
  logic        halt_q;

  logic [7:0]  first_byte;
  logic [7:0]  next_byte;

  assign first_byte = get_byte(bus.mem_data, 2'd0);
  assign next_byte  = get_byte(word, bidx + 2'd1);

  // In IDLE the stall must react in the same cycle the syscall reaches decode.
  assign bus.stall     = (state == ST_IDLE) ? bus.sys : (state != ST_DONE);
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.con_valid = con_valid_q;
  assign bus.con_type  = con_type_q;
  assign bus.con_data  = con_data_q;
  assign bus.halt      = halt_q;

  // Console outputs are loaded for the state being entered, so a NUL byte is
  // detected one step ahead and never occupies an EMIT cycle of its own.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block and every state
    // update uses non-blocking assignment so all registers see pre-edge values.
    if (reset) begin
      state       <= ST_IDLE;
      loc         <= '0;
      widx        <= '0;
      bidx        <= '0;
      word        <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      con_valid_q <= 1'b0;
      con_type_q  <= CON_CHAR;
      con_data_q  <= '0;
      halt_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.sys) begin
            loc  <= bus.rega[29:0];
            widx <= '0;
            bidx <= '0;
            case (bus.regv)
              SYS_PRINT_INT: begin
                state       <= ST_INT;
                con_valid_q <= 1'b1;
                con_type_q  <= CON_INT;
                con_data_q  <= bus.rega;
              end
              SYS_PRINT_STR: begin
                state      <= ST_FETCH;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= bus.rega[29:0];
              end
              SYS_EXIT: begin
                state  <= ST_HALT;
                halt_q <= 1'b1;
              end
              default: state <= ST_DONE;
            endcase
          end
        end

        ST_INT: begin
          if (bus.con_ready) begin
            state      <= ST_NL;
            con_type_q <= CON_CHAR;
            con_data_q <= CON_NEWLINE;
          end
        end

        ST_FETCH: begin
          mem_rd_q <= 1'b0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          word        <= bus.mem_data;
          con_valid_q <= 1'b1;
          con_type_q  <= CON_CHAR;
          if (first_byte == 8'h00) begin
            state      <= ST_NL;
            con_data_q <= CON_NEWLINE;
          end else begin
            state      <= ST_EMIT;
            con_data_q <= {24'b0, first_byte};
          end
        end

        ST_EMIT: begin
          if (bus.con_ready) begin
            if (bidx == 2'd3) begin
              bidx <= 2'd0;
              widx <= widx + widx_t'(1);
              loc  <= loc + 30'd1;
              if (widx == LAST_WIDX) begin
                state      <= ST_NL;
                con_data_q <= CON_NEWLINE;
              end else begin
                state       <= ST_FETCH;
                con_valid_q <= 1'b0;
                mem_rd_q    <= 1'b1;
                mem_addr_q  <= loc + 30'd1;
              end
            end else if (next_byte == 8'h00) begin
              state      <= ST_NL;
              con_data_q <= CON_NEWLINE;
            end else begin
              bidx       <= bidx + 2'd1;
              con_data_q <= {24'b0, next_byte};
            end
          end
        end

        ST_NL: begin
          if (bus.con_ready) begin
            state       <= ST_DONE;
            con_valid_q <= 1'b0;
            con_data_q  <= '0;
          end
        end

        ST_DONE: state <= ST_IDLE;

        ST_HALT: state <= ST_HALT;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/syscall_ctrl.md
# syscall_ctrl

Decode-side syscall sequencer for the pipelined MIPS core. When a `syscall` sits in decode, it stalls the pipeline, samples `$v0`/`$a0`, and services print-int (v0=1), print-string (v0=4) or exit (v0=10). It reads string words through a dedicated read port on the instruction/data memory and emits characters and integers on a valid/ready console stream. It then releases the stall, or halts the core.

## Interface
- `MAX_WORDS`, 256: maximum string length in words before forced termination.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `sys` in 1: decode stage holds a `syscall` this cycle.
- `regv` in 32: forwarded `$v0` value, valid while `sys`=1.
- `rega` in 32: forwarded `$a0` value, valid while `sys`=1.
- `stall` out 1: freeze fetch/decode; hold later stages.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out 30: word address, same indexing as the PC.
- `mem_data` in 32: read data, valid the cycle after `mem_rd`.
- `con_valid` out 1: console item valid.
- `con_ready` in 1: console accepts the item.
- `con_type` out 2: 0 = char in `con_data[7:0]`; 1 = signed int in `con_data`.
- `con_data` out 32: console payload.
- `halt` out 1: exit reached; sticky until reset.

## Operation
- States: IDLE, INT, FETCH, WAIT, EMIT, NL, DONE, HALT.
- IDLE:
  - `stall` = `sys` (combinational).
  - On `sys`, latch v0 and a0. Load `loc` = a0[29:0], `widx` = 0, `bidx` = 0.
  - Next state by v0: 1 → INT; 4 → FETCH; 10 → HALT; any other value → DONE (no output).
- INT: `con_valid`=1, `con_type`=1, `con_data`=a0. Go to NL on `con_ready`.
- FETCH: `mem_rd`=1, `mem_addr`=`loc`. Go to WAIT.
- WAIT: capture `mem_data` into `word`. Go to EMIT.
- EMIT:
  - Current byte is `word[8*bidx+7 : 8*bidx]`, so byte 0 = bits [7:0] (little-endian).
  - Byte == 0x00 → NL, with no handshake for the NUL.
  - Otherwise `con_valid`=1, `con_type`=0, `con_data`={24'b0, byte}.
  - On `con_ready`: if `bidx`=3, set `bidx`=0, `loc`+=1, `widx`+=1, and go to FETCH, or to NL if `widx`+1 == `MAX_WORDS`. Else `bidx`+=1 and stay in EMIT.
- NL: `con_valid`=1, `con_type`=0, `con_data`=0x0A. Go to DONE on `con_ready`.
- DONE:
  - `stall`=0 for exactly one cycle so the syscall leaves decode. Go to IDLE.
  - `sys` seen in DONE belongs to the retiring syscall and is ignored.
- HALT: `halt`=1, `stall`=1. Stays in HALT until reset.
- `stall`=1 in every state except IDLE (where it equals `sys`) and DONE.
- `loc` wraps modulo 2^30. `widx` is wide enough to count to `MAX_WORDS`.

## Timing
- Reset (applies at any state, including mid-string or mid-handshake):
  - State goes to IDLE.
  - Outputs: `stall`=0, `mem_rd`=0, `mem_addr`=0, `con_valid`=0, `con_type`=0, `con_data`=0, `halt`=0.
  - Latched registers are cleared.
- `con_valid`/`con_type`/`con_data` are registered or state-decoded, never combinationally dependent on `con_ready`. They are held stable until accepted.
- Memory read latency is exactly 1 cycle: FETCH issues, WAIT samples.
- Latency with `con_ready` held high:
  - print-int: 4 cycles from `sys` to `stall` low (IDLE, INT, NL, DONE).
  - print-string of N chars ending in a NUL inside word k: 1 + 2(k+1) + N + 1 + 1 cycles.
- Unknown v0: `stall` is high for one cycle (IDLE), then low in DONE.
- Back-to-back syscalls: a second `sys` is honored at the earliest on the cycle after DONE.

## Structure
- Shared package `mips_pkg`:
  - Syscall code constants `SYS_PRINT_INT`=1, `SYS_PRINT_STR`=4, `SYS_EXIT`=10.
  - Console type constants `CON_CHAR`=0, `CON_INT`=1.
  - State enum typedef.
- Single module with no sub-modules.
- The console sink (simulation `$write`/`$display` printer) lives in the testbench, outside this block.

## Test plan
- Print-int: v0=1, a0=0xFFFFFFF9, `con_ready`=1.
  - Required: one INT item with `con_data`=0xFFFFFFF9, then a char 0x0A.
  - `stall` high for 3 cycles, then low for 1 cycle.
- Print-string: v0=4, a0=0x00100024; memory[0x100024]=0x6C6C6548, memory[0x100025]=0x0000006F.
  - Required: chars 'H','e','l','l','o', then 0x0A.
  - `mem_rd` pulses at exactly 2 addresses; the NUL byte is not emitted.
- Backpressure: same string with `con_ready` toggling 1,0,0,1.
  - Required: each char is held unchanged while not ready, with no duplicate or lost characters.
- Exit: v0=10.
  - Required: `halt`=1 from the next cycle; `stall`=1 stays high; no console traffic; further `sys` pulses are ignored.
- Runaway and reset:
  - `MAX_WORDS`=2 with memory containing no NUL: required output is 8 chars, then 0x0A.
  - Separately, reset asserted mid-EMIT: all outputs must be 0 on the next cycle, and the following print-int must work normally.
- Unknown code v0=7: no `mem_rd`, no `con_valid`; `stall` high 1 cycle, then low.
